// File: rtl/fetch_stage.sv
// F-stage front end: program counter, single-outstanding instruction fetch,
// one-entry hold buffer for responses that arrive while D is stalled, and
// the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        PCSrcD,
    input  logic [31:0] addrResult,
    input  logic        stallD,
    input  logic        flushD,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemValid,
    input  logic [31:0] imemRdata,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] instrD,
    output logic [31:0] PCPlus4D,
    output logic        validD
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,  // request outstanding at PCF
        HOLD    = 2'd1,  // response parked in the buffer, waiting for D
        DISCARD = 2'd2   // waiting to drop a wrong-path response
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_d_reg, instr_d_next;
    logic [31:0] pc_plus4_d_reg, pc_plus4_d_next;
    logic        valid_d_reg, valid_d_next;
    logic [31:0] buf_instr_reg, buf_instr_next;
    logic [31:0] buf_pc_plus4_reg, buf_pc_plus4_next;
    logic        buf_valid_reg, buf_valid_next;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        bubble;

    // A redirect is only honoured when D actually advances.
    assign redirect = PCSrcD & ~stallD;
    assign target   = addrResult & 32'hFFFF_FFFC;
    assign pc_plus4 = pc_reg + 32'd4;

    assign imemReq  = (state_reg == FETCH);
    assign imemAddr = pc_reg;
    assign PCF      = pc_reg;
    assign PCPlus4F = pc_plus4;
    assign instrD   = instr_d_reg;
    assign PCPlus4D = pc_plus4_d_reg;
    assign validD   = valid_d_reg;

    // Control state and program counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // IF/ID register and hold buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_d_reg      <= NOP_INSTR;
            pc_plus4_d_reg   <= 32'd0;
            valid_d_reg      <= 1'b0;
            buf_instr_reg    <= NOP_INSTR;
            buf_pc_plus4_reg <= 32'd0;
            buf_valid_reg    <= 1'b0;
        end else begin
            instr_d_reg      <= instr_d_next;
            pc_plus4_d_reg   <= pc_plus4_d_next;
            valid_d_reg      <= valid_d_next;
            buf_instr_reg    <= buf_instr_next;
            buf_pc_plus4_reg <= buf_pc_plus4_next;
            buf_valid_reg    <= buf_valid_next;
        end
    end

    // Next-state, PC selection and IF/ID update; redirect beats normal PC advance.
    always_comb begin
        state_next        = state_reg;
        pc_next           = pc_reg;
        instr_d_next      = instr_d_reg;
        pc_plus4_d_next   = pc_plus4_d_reg;
        valid_d_next      = valid_d_reg;
        buf_instr_next    = buf_instr_reg;
        buf_pc_plus4_next = buf_pc_plus4_reg;
        buf_valid_next    = buf_valid_reg;
        bubble            = 1'b0;

        case (state_reg)
            FETCH: begin
                if (redirect) begin
                    // Squash the wrong-path fetch; if its data is not back
                    // yet it must be drained before a new request goes out.
                    pc_next        = target;
                    bubble         = 1'b1;
                    buf_valid_next = 1'b0;
                    state_next     = imemValid ? FETCH : DISCARD;
                end else if (imemValid && !stallD) begin
                    instr_d_next    = imemRdata;
                    pc_plus4_d_next = pc_plus4;
                    valid_d_next    = 1'b1;
                    pc_next         = pc_plus4;
                end else if (imemValid) begin
                    buf_instr_next    = imemRdata;
                    buf_pc_plus4_next = pc_plus4;
                    buf_valid_next    = 1'b1;
                    state_next        = HOLD;
                end else if (!stallD) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next        = target;
                    bubble         = 1'b1;
                    buf_valid_next = 1'b0;
                    state_next     = FETCH;
                end else if (!stallD) begin
                    instr_d_next    = buf_instr_reg;
                    pc_plus4_d_next = buf_pc_plus4_reg;
                    valid_d_next    = buf_valid_reg;
                    buf_valid_next  = 1'b0;
                    pc_next         = pc_plus4;
                    state_next      = FETCH;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_next = target;
                    bubble  = 1'b1;
                end else if (!stallD) begin
                    bubble = 1'b1;
                end
                // The stale word is dropped whenever it shows up, even when a
                // second redirect lands in the same cycle, so we never wait
                // for a response that has already gone by.
                if (imemValid) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        if (bubble || flushD) begin
            instr_d_next    = NOP_INSTR;
            pc_plus4_d_next = 32'd0;
            valid_d_next    = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the multi-cycle corner
// cases, a hand-written asynchronous reset pulse, then randomized traffic
// compared against a queue-based reference model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic        PCSrcD;
    logic [31:0] addrResult;
    logic        stallD;
    logic        flushD;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid;
    logic [31:0] imemRdata;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic [31:0] instrD;
    logic [31:0] PCPlus4D;
    logic        validD;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .PCSrcD     (PCSrcD),
        .addrResult (addrResult),
        .stallD     (stallD),
        .flushD     (flushD),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemValid  (imemValid),
        .imemRdata  (imemRdata),
        .PCF        (PCF),
        .PCPlus4F   (PCPlus4F),
        .instrD     (instrD),
        .PCPlus4D   (PCPlus4D),
        .validD     (validD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        pcsrc;
        logic [31:0] addr;
        logic        stall;
        logic        flush;
        logic        valid;
        logic [31:0] rdata;
        logic        exp_req;    // during the cycle
        logic [31:0] exp_pcf;    // during the cycle
        logic        exp_vd;     // after the edge
        logic [31:0] exp_instr;  // after the edge
        logic [31:0] exp_pc4d;   // after the edge
    } row_t;

    row_t rows[$];

    function automatic void add(input logic pcsrc, input logic [31:0] addr,
                                input logic stall, input logic flush,
                                input logic valid, input logic [31:0] rdata,
                                input logic ereq, input logic [31:0] epcf,
                                input logic evd, input logic [31:0] einstr,
                                input logic [31:0] epc4d);
        row_t r;
        r.pcsrc = pcsrc; r.addr = addr; r.stall = stall; r.flush = flush;
        r.valid = valid; r.rdata = rdata; r.exp_req = ereq; r.exp_pcf = epcf;
        r.exp_vd = evd; r.exp_instr = einstr; r.exp_pc4d = epc4d;
        rows.push_back(r);
    endfunction

    task automatic run_row(input int idx);
        row_t r;
        r = rows[idx];
        @(negedge clk);
        PCSrcD = r.pcsrc; addrResult = r.addr; stallD = r.stall;
        flushD = r.flush; imemValid = r.valid; imemRdata = r.rdata;
        #1;
        chk($sformatf("row%0d imemReq", idx), {31'b0, imemReq}, {31'b0, r.exp_req});
        if (r.exp_req) chk($sformatf("row%0d imemAddr", idx), imemAddr, r.exp_pcf);
        chk($sformatf("row%0d PCF", idx), PCF, r.exp_pcf);
        chk($sformatf("row%0d PCPlus4F", idx), PCPlus4F, r.exp_pcf + 32'd4);
        @(posedge clk);
        #1;
        chk($sformatf("row%0d validD", idx), {31'b0, validD}, {31'b0, r.exp_vd});
        chk($sformatf("row%0d instrD", idx), instrD, r.exp_instr);
        if (r.exp_vd) chk($sformatf("row%0d PCPlus4D", idx), PCPlus4D, r.exp_pc4d);
        $display("row %0d: pcf=%h req=%b -> validD=%b instrD=%h PCPlus4D=%h",
                 idx, r.exp_pcf, r.exp_req, validD, instrD, PCPlus4D);
    endtask

    task automatic idle_inputs();
        PCSrcD = 1'b0; addrResult = 32'd0; stallD = 1'b0;
        flushD = 1'b0; imemValid = 1'b0; imemRdata = 32'd0;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } held_t;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4d;
    logic        m_valid;
    held_t       m_hq[$];   // word waiting for D to accept it
    logic        m_stale;   // a wrong-path response is still owed by memory

    task automatic model_reset();
        m_pc = RST_PC; m_instr = NOP; m_pc4d = 32'd0; m_valid = 1'b0;
        m_hq.delete(); m_stale = 1'b0;
    endtask

    task automatic model_step();
        logic        go;
        logic [31:0] tgt;
        logic        bub;
        go  = PCSrcD && !stallD;
        tgt = {addrResult[31:2], 2'b00};
        bub = 1'b0;
        if (m_hq.size() != 0) begin
            if (go) begin
                m_pc = tgt; m_hq.delete(); bub = 1'b1;
            end else if (!stallD) begin
                m_instr = m_hq[0].instr; m_pc4d = m_hq[0].pc4; m_valid = 1'b1;
                m_hq.delete(); m_pc = m_pc + 32'd4;
            end
        end else if (m_stale) begin
            if (imemValid) m_stale = 1'b0;
            if (go) begin
                m_pc = tgt; bub = 1'b1;
            end else if (!stallD) begin
                bub = 1'b1;
            end
        end else begin
            if (go) begin
                m_pc = tgt; bub = 1'b1; m_stale = !imemValid;
            end else if (imemValid && !stallD) begin
                m_instr = imemRdata; m_pc4d = m_pc + 32'd4; m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end else if (imemValid) begin
                m_hq.push_back(held_t'{imemRdata, m_pc + 32'd4});
            end else if (!stallD) begin
                bub = 1'b1;
            end
        end
        if (bub || flushD) begin
            m_instr = NOP; m_pc4d = 32'd0; m_valid = 1'b0;
        end
    endtask

    initial begin
        logic        exp_req;
        logic        mem_busy;
        int          mem_cnt;

        idle_inputs();
        reset_n = 1'b0;
        #12;
        chk("reset PCF", PCF, RST_PC);
        chk("reset validD", {31'b0, validD}, 32'd0);
        chk("reset instrD", instrD, NOP);
        chk("reset PCPlus4D", PCPlus4D, 32'd0);
        chk("reset imemReq", {31'b0, imemReq}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // zero-wait fetches
        add(0, 0, 0, 0, 0, 0,            1, 32'h0040_0000, 0, NOP, 0);
        add(0, 0, 0, 0, 1, 32'h2408_0001, 1, 32'h0040_0000, 1, 32'h2408_0001, 32'h0040_0004);
        add(0, 0, 0, 0, 0, 0,            1, 32'h0040_0004, 0, NOP, 0);
        add(0, 0, 0, 0, 1, 32'h2409_0002, 1, 32'h0040_0004, 1, 32'h2409_0002, 32'h0040_0008);
        add(0, 0, 0, 0, 0, 0,            1, 32'h0040_0008, 0, NOP, 0);
        add(0, 0, 0, 0, 1, 32'h012A_5820, 1, 32'h0040_0008, 1, 32'h012A_5820, 32'h0040_000C);
        // three-cycle latency
        add(0, 0, 0, 0, 0, 0,            1, 32'h0040_000C, 0, NOP, 0);
        add(0, 0, 0, 0, 0, 0,            1, 32'h0040_000C, 0, NOP, 0);
        add(0, 0, 0, 0, 1, 32'hAC0B_0010, 1, 32'h0040_000C, 1, 32'hAC0B_0010, 32'h0040_0010);
        // response under stall goes to the hold buffer
        add(0, 0, 1, 0, 0, 0,            1, 32'h0040_0010, 1, 32'hAC0B_0010, 32'h0040_0010);
        add(0, 0, 1, 0, 1, 32'h8C22_0004, 1, 32'h0040_0010, 1, 32'hAC0B_0010, 32'h0040_0010);
        add(0, 0, 1, 0, 0, 0,            0, 32'h0040_0010, 1, 32'hAC0B_0010, 32'h0040_0010);
        add(0, 0, 0, 0, 0, 0,            0, 32'h0040_0010, 1, 32'h8C22_0004, 32'h0040_0014);
        // redirect with a request outstanding, stale word dropped
        add(0, 0, 0, 0, 0, 0,            1, 32'h0040_0014, 0, NOP, 0);
        add(1, 32'h0040_0103, 0, 0, 0, 0, 1, 32'h0040_0014, 0, NOP, 0);
        add(0, 0, 0, 0, 0, 0,            0, 32'h0040_0100, 0, NOP, 0);
        add(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0040_0100, 0, NOP, 0);
        add(0, 0, 0, 0, 0, 0,            1, 32'h0040_0100, 0, NOP, 0);
        add(0, 0, 0, 0, 1, 32'h1000_FFFF, 1, 32'h0040_0100, 1, 32'h1000_FFFF, 32'h0040_0104);
        // redirect ignored under stall, taken once stall drops
        add(1, 32'h0050_0000, 1, 0, 0, 0, 1, 32'h0040_0104, 1, 32'h1000_FFFF, 32'h0040_0104);
        add(1, 32'h0050_0000, 0, 0, 0, 0, 1, 32'h0040_0104, 0, NOP, 0);
        add(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0050_0000, 0, NOP, 0);
        add(0, 0, 0, 0, 0, 0,            1, 32'h0050_0000, 0, NOP, 0);
        add(0, 0, 0, 0, 1, 32'h3C01_1234, 1, 32'h0050_0000, 1, 32'h3C01_1234, 32'h0050_0004);
        // flush beats stall; flushed response still advances PCF
        add(0, 0, 1, 1, 0, 0,            1, 32'h0050_0004, 0, NOP, 0);
        add(0, 0, 0, 1, 1, 32'h3421_5678, 1, 32'h0050_0004, 0, NOP, 0);
        add(0, 0, 0, 0, 0, 0,            1, 32'h0050_0008, 0, NOP, 0);
        // enter HOLD ahead of the reset pulse
        add(0, 0, 1, 0, 1, 32'hCAFE_0001, 1, 32'h0050_0008, 0, NOP, 0);
        // after the reset pulse: fresh fetch, then redirect to the top and wrap
        add(0, 0, 0, 0, 0, 0,            1, 32'h0040_0000, 0, NOP, 0);
        add(0, 0, 0, 0, 1, 32'h2402_000A, 1, 32'h0040_0000, 1, 32'h2402_000A, 32'h0040_0004);
        add(0, 0, 0, 0, 0, 0,            1, 32'h0040_0004, 0, NOP, 0);
        add(1, 32'hFFFF_FFFF, 0, 0, 1, 32'h1111_1111, 1, 32'h0040_0004, 0, NOP, 0);
        add(0, 0, 0, 0, 0, 0,            1, 32'hFFFF_FFFC, 0, NOP, 0);
        add(0, 0, 0, 0, 1, 32'h0800_0000, 1, 32'hFFFF_FFFC, 1, 32'h0800_0000, 32'h0000_0000);
        add(0, 0, 0, 0, 0, 0,            1, 32'h0000_0000, 0, NOP, 0);

        for (int i = 0; i < 28; i++) run_row(i);

        // asynchronous reset in the middle of HOLD
        @(negedge clk);
        idle_inputs();
        #1;
        chk("hold imemReq", {31'b0, imemReq}, 32'd0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async reset PCF", PCF, RST_PC);
        chk("async reset validD", {31'b0, validD}, 32'd0);
        chk("async reset instrD", instrD, NOP);
        chk("async reset PCPlus4D", PCPlus4D, 32'd0);
        chk("async reset imemReq", {31'b0, imemReq}, 32'd1);
        $display("reset pulse: PCF=%h validD=%b imemReq=%b", PCF, validD, imemReq);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 28; i < rows.size(); i++) run_row(i);

        // ---------------- randomized traffic vs. model ----------------
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        mem_busy = 1'b0;
        mem_cnt  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            exp_req   = (m_hq.size() == 0) && !m_stale;
            imemValid = 1'b0;
            imemRdata = $urandom;
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imemValid = 1'b1;
                    mem_busy  = 1'b0;
                end
            end else if (exp_req) begin
                mem_busy = 1'b1;
                mem_cnt  = $urandom_range(1, 4);
            end
            stallD     = ($urandom_range(0, 3) == 0);
            flushD     = ($urandom_range(0, 9) == 0);
            PCSrcD     = ($urandom_range(0, 9) == 0);
            addrResult = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            #1;
            chk("rand imemReq", {31'b0, imemReq}, {31'b0, exp_req});
            if (exp_req) chk("rand imemAddr", imemAddr, m_pc);
            chk("rand PCF", PCF, m_pc);
            chk("rand PCPlus4F", PCPlus4F, m_pc + 32'd4);
            chk("rand validD", {31'b0, validD}, {31'b0, m_valid});
            chk("rand instrD", instrD, m_instr);
            if (m_valid) chk("rand PCPlus4D", PCPlus4D, m_pc4d);
            @(posedge clk);
            model_step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
